// File: rtl/nibble_fifo_ctrl.sv
// FIFO controller driving both ports of an external 4096x4 dual-port RAM.
// Port A writes and port B reads; read data returns one cycle after the accepted read.
module nibble_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 4,
  parameter int AFULL_THRESH  = 4092,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRB,
  output logic [DATA_WIDTH-1:0] RAM_DIA,
  output logic                  RAM_ENA,
  output logic                  RAM_WEA,
  output logic                  RAM_SSRA,
  output logic                  RAM_ENB,
  output logic                  RAM_WEB,
  output logic                  RAM_SSRB,
  input  logic [DATA_WIDTH-1:0] RAM_DOB
);
  localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr, r_count;
  logic                r_full, r_empty, r_afull, r_aempty;
  logic                r_rd_valid, r_ovf, r_unf;
  logic                w_wr_acc, w_rd_acc;
  logic [ADDR_WIDTH:0] w_count_nxt;

  // Full/empty gating keeps both ports off the same address in any one cycle.
  assign w_wr_acc    = WR_EN & ~r_full  & ~FLUSH;
  assign w_rd_acc    = RD_EN & ~r_empty & ~FLUSH;
  assign w_count_nxt = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_acc}
                               - {{ADDR_WIDTH{1'b0}}, w_rd_acc};

  // RAM enables drop while in reset so an async reset never disturbs contents.
  assign RAM_ENA   = w_wr_acc & RST_N;
  assign RAM_WEA   = w_wr_acc & RST_N;
  assign RAM_ADDRA = r_wr_ptr[ADDR_WIDTH-1:0];
  assign RAM_DIA   = WR_DATA;
  assign RAM_SSRA  = 1'b0;
  assign RAM_ENB   = (w_rd_acc | FLUSH) & RST_N;
  assign RAM_ADDRB = r_rd_ptr[ADDR_WIDTH-1:0];
  assign RAM_WEB   = 1'b0;
  assign RAM_SSRB  = FLUSH;

  assign RD_DATA      = RAM_DOB;
  assign RD_VALID     = r_rd_valid;
  assign COUNT        = r_count;
  assign FULL         = r_full;
  assign EMPTY        = r_empty;
  assign ALMOST_FULL  = r_afull;
  assign ALMOST_EMPTY = r_aempty;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_unf;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (FLUSH) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      // Wrap bit is the pointer MSB; it toggles as the address rolls past the top.
      r_wr_ptr   <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
      r_rd_ptr   <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH);
      r_empty    <= (w_count_nxt == '0);
      r_afull    <= (w_count_nxt >= AFULL);
      r_aempty   <= (w_count_nxt <= AEMPTY);
      r_rd_valid <= w_rd_acc;
      r_ovf      <= WR_EN & r_full;
      r_unf      <= RD_EN & r_empty;
    end
  end
endmodule

// File: tb/tb_nibble_fifo_ctrl.sv
// Directed bench for nibble_fifo_ctrl with a behavioural 4096x4 dual-port RAM attached.
module tb_nibble_fifo_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N, FLUSH, WR_EN, RD_EN;
  logic [3:0]  WR_DATA, RD_DATA, RAM_DIA, RAM_DOB;
  logic        RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [12:0] COUNT;
  logic [11:0] RAM_ADDRA, RAM_ADDRB;
  logic        RAM_ENA, RAM_WEA, RAM_SSRA, RAM_ENB, RAM_WEB, RAM_SSRB;

  int checks = 0;
  int errors = 0;
  logic [3:0] mem [0:4095];
  logic [3:0] q [$];
  logic [3:0] exp_d;

  always #5 CLK = ~CLK;

  // RAM model: write-port A, registered read port B with SRVAL_B = 0.
  initial RAM_DOB = 4'h0;
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
    if (RAM_ENB) RAM_DOB <= RAM_SSRB ? 4'h0 : mem[RAM_ADDRB];
  end

  nibble_fifo_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .RAM_ADDRA(RAM_ADDRA), .RAM_ADDRB(RAM_ADDRB),
    .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_SSRA(RAM_SSRA),
    .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_SSRB(RAM_SSRB), .RAM_DOB(RAM_DOB)
  );

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; FLUSH = 0; WR_EN = 0; RD_EN = 0; WR_DATA = 0;
    #12;
    checks++; if (COUNT !== 13'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    checks++; if ({EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b exp 1100", {EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL}); end
    checks++; if ({RD_VALID, OVERFLOW, UNDERFLOW} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {RD_VALID, OVERFLOW, UNDERFLOW}); end
    RST_N = 1'b1;
    cyc(); cyc();
    checks++; if ({RAM_ENA, RAM_WEA, RAM_ENB, RAM_WEB, RAM_SSRA, RAM_SSRB} !== 6'b0) begin errors++; $display("FAIL idle_ram_ctrl got %b exp 000000", {RAM_ENA, RAM_WEA, RAM_ENB, RAM_WEB, RAM_SSRA, RAM_SSRB}); end
    checks++; if ({COUNT, EMPTY, ALMOST_EMPTY} !== {13'd0, 2'b11}) begin errors++; $display("FAIL idle_state got %0d/%b%b exp 0/11", COUNT, EMPTY, ALMOST_EMPTY); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4096; i++) begin
      WR_EN = 1; WR_DATA = 4'(i % 16); #1;
      checks++; if ({RAM_ENA, RAM_WEA} !== 2'b11 || RAM_ADDRA !== 12'(i) || RAM_DIA !== 4'(i % 16)) begin
        errors++; $display("FAIL fill_porta i=%0d en=%b addr=%0d exp addr %0d", i, {RAM_ENA, RAM_WEA}, RAM_ADDRA, i); end
      cyc();
      checks++; if (COUNT !== 13'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", COUNT, i + 1); end
      checks++; if ({FULL, ALMOST_FULL, ALMOST_EMPTY, EMPTY} !== {(i + 1 == 4096), (i + 1 >= 4092), (i + 1 <= 4), 1'b0}) begin
        errors++; $display("FAIL fill_flags cnt=%0d got F/AF/AE/E=%b", i + 1, {FULL, ALMOST_FULL, ALMOST_EMPTY, EMPTY}); end
    end
    WR_DATA = 4'hF; #1;
    checks++; if (RAM_ENA !== 1'b0) begin errors++; $display("FAIL full_write_gated got ena=%b exp 0", RAM_ENA); end
    cyc();
    checks++; if (OVERFLOW !== 1'b1 || COUNT !== 13'd4096) begin errors++; $display("FAIL overflow got ovf=%b cnt=%0d exp 1/4096", OVERFLOW, COUNT); end
    WR_EN = 0; cyc();
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b exp 0", OVERFLOW); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4096; i++) begin
      RD_EN = 1; #1;
      checks++; if (RAM_ENB !== 1'b1 || RAM_ADDRB !== 12'(i) || RAM_WEB !== 1'b0) begin
        errors++; $display("FAIL drain_portb i=%0d enb=%b addr=%0d", i, RAM_ENB, RAM_ADDRB); end
      cyc();
      checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 4'(i % 16)) begin
        errors++; $display("FAIL drain_data i=%0d got v=%b d=%h exp 1/%h", i, RD_VALID, RD_DATA, 4'(i % 16)); end
      checks++; if (COUNT !== 13'(4095 - i)) begin errors++; $display("FAIL drain_count got %0d exp %0d", COUNT, 4095 - i); end
    end
    checks++; if (EMPTY !== 1'b1 || ALMOST_EMPTY !== 1'b1) begin errors++; $display("FAIL drain_empty got %b%b exp 11", EMPTY, ALMOST_EMPTY); end
    #1;
    checks++; if (RAM_ENB !== 1'b0) begin errors++; $display("FAIL empty_read_gated got enb=%b exp 0", RAM_ENB); end
    cyc();
    checks++; if (UNDERFLOW !== 1'b1 || RD_VALID !== 1'b0 || COUNT !== 13'd0) begin
      errors++; $display("FAIL underflow got u=%b v=%b cnt=%0d exp 1/0/0", UNDERFLOW, RD_VALID, COUNT); end
    RD_EN = 0; cyc();
    checks++; if (UNDERFLOW !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b exp 0", UNDERFLOW); end
  endtask

  task automatic test_wrap();
    q.delete();
    for (int i = 0; i < 3000; i++) begin
      WR_EN = 1; WR_DATA = 4'((i * 5 + 1) % 16); q.push_back(WR_DATA); cyc();
    end
    WR_EN = 0;
    checks++; if (COUNT !== 13'd3000) begin errors++; $display("FAIL wrap_fill_count got %0d exp 3000", COUNT); end
    for (int i = 0; i < 3000; i++) begin
      RD_EN = 1; cyc(); exp_d = q.pop_front();
      checks++; if (RD_VALID !== 1'b1 || RD_DATA !== exp_d) begin errors++; $display("FAIL wrap_drain i=%0d got %h exp %h", i, RD_DATA, exp_d); end
    end
    RD_EN = 0;
    WR_EN = 1; WR_DATA = 4'hA; q.push_back(WR_DATA); cyc();
    for (int i = 0; i < 2000; i++) begin
      WR_EN = 1; RD_EN = 1; WR_DATA = 4'((i * 7 + 3) % 16); q.push_back(WR_DATA); #1;
      checks++; if (RAM_ADDRA !== 12'((3001 + i) % 4096) || RAM_ADDRB !== 12'((3000 + i) % 4096)) begin
        errors++; $display("FAIL wrap_addr i=%0d got a=%0d b=%0d", i, RAM_ADDRA, RAM_ADDRB); end
      cyc(); exp_d = q.pop_front();
      checks++; if (RD_VALID !== 1'b1 || RD_DATA !== exp_d || COUNT !== 13'd1) begin
        errors++; $display("FAIL wrap_stream i=%0d got d=%h cnt=%0d exp %h/1", i, RD_DATA, COUNT, exp_d); end
    end
    WR_EN = 0; RD_EN = 1; cyc(); exp_d = q.pop_front(); RD_EN = 0;
    checks++; if (RD_DATA !== exp_d || EMPTY !== 1'b1) begin errors++; $display("FAIL wrap_last got %h e=%b exp %h/1", RD_DATA, EMPTY, exp_d); end
  endtask

  task automatic test_simultaneous();
    WR_EN = 1; WR_DATA = 4'h3;
    for (int i = 0; i < 4096; i++) cyc();
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL sim_full got %b exp 1", FULL); end
    RD_EN = 1; #1;
    checks++; if (RAM_ENA !== 1'b0 || RAM_ENB !== 1'b1) begin errors++; $display("FAIL sim_full_ports got a=%b b=%b exp 0/1", RAM_ENA, RAM_ENB); end
    cyc();
    checks++; if (OVERFLOW !== 1'b1 || UNDERFLOW !== 1'b0 || COUNT !== 13'd4095 || FULL !== 1'b0 || RD_VALID !== 1'b1) begin
      errors++; $display("FAIL sim_full got o=%b u=%b cnt=%0d f=%b v=%b exp 1/0/4095/0/1", OVERFLOW, UNDERFLOW, COUNT, FULL, RD_VALID); end
    WR_EN = 0;
    for (int i = 0; i < 4095; i++) cyc();
    checks++; if (EMPTY !== 1'b1 || COUNT !== 13'd0) begin errors++; $display("FAIL sim_drain got e=%b cnt=%0d exp 1/0", EMPTY, COUNT); end
    WR_EN = 1; #1;
    checks++; if (RAM_ENA !== 1'b1 || RAM_ENB !== 1'b0) begin errors++; $display("FAIL sim_empty_ports got a=%b b=%b exp 1/0", RAM_ENA, RAM_ENB); end
    cyc();
    checks++; if (UNDERFLOW !== 1'b1 || OVERFLOW !== 1'b0 || COUNT !== 13'd1 || RD_VALID !== 1'b0) begin
      errors++; $display("FAIL sim_empty got u=%b o=%b cnt=%0d v=%b exp 1/0/1/0", UNDERFLOW, OVERFLOW, COUNT, RD_VALID); end
    WR_EN = 0; cyc(); RD_EN = 0; cyc();
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL sim_empty_end got %b exp 1", EMPTY); end
  endtask

  task automatic test_flush();
    WR_EN = 1; WR_DATA = 4'h9;
    for (int i = 0; i < 100; i++) cyc();
    WR_EN = 0;
    checks++; if (COUNT !== 13'd100) begin errors++; $display("FAIL flush_pre got %0d exp 100", COUNT); end
    RD_EN = 1; WR_EN = 1; FLUSH = 1; #1;
    checks++; if (RAM_SSRB !== 1'b1 || RAM_ENB !== 1'b1 || RAM_ENA !== 1'b0) begin
      errors++; $display("FAIL flush_ports got ssrb=%b enb=%b ena=%b exp 1/1/0", RAM_SSRB, RAM_ENB, RAM_ENA); end
    cyc();
    checks++; if (COUNT !== 13'd0 || EMPTY !== 1'b1 || ALMOST_EMPTY !== 1'b1 || RD_VALID !== 1'b0 || UNDERFLOW !== 1'b0) begin
      errors++; $display("FAIL flush_state got cnt=%0d e=%b ae=%b v=%b u=%b", COUNT, EMPTY, ALMOST_EMPTY, RD_VALID, UNDERFLOW); end
    checks++; if (RD_DATA !== 4'h0) begin errors++; $display("FAIL flush_srval got %h exp 0", RD_DATA); end
    FLUSH = 0; RD_EN = 0; WR_EN = 0; cyc();
  endtask

  task automatic test_reset_mid();
    WR_EN = 1; WR_DATA = 4'h5;
    for (int i = 0; i < 10; i++) cyc();
    RD_EN = 1; #2;
    RST_N = 1'b0; #1;
    checks++; if (COUNT !== 13'd0 || EMPTY !== 1'b1 || FULL !== 1'b0 || RD_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_mid_state got cnt=%0d e=%b f=%b v=%b", COUNT, EMPTY, FULL, RD_VALID); end
    checks++; if (RAM_ENA !== 1'b0 || RAM_WEA !== 1'b0 || RAM_ENB !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ram got ena=%b wea=%b enb=%b exp 000", RAM_ENA, RAM_WEA, RAM_ENB); end
    WR_EN = 0; RD_EN = 0; cyc();
    RST_N = 1'b1; cyc();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
